rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port controller for the 8-entry processor register file. It arbitrates two writeback requesters onto the single register-file write port: requester A is the pipeline ALU/load path and requester B is the multicycle unit. It also keeps a per-register scoreboard of outstanding writes, so decode can stall readers of in-flight registers. It sits between the writeback stage(s) and the register file write inputs.

## Interface
Parameters:
- DATA_W, 8, writeback data width
- ADDR_W, 3, register address width; NREG = 2**ADDR_W registers

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- a_valid  in  1  requester A has a write
- a_addr  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write data
- a_ready  out  1  A granted this cycle
- b_valid, b_addr, b_data, b_ready  same as A, for requester B
- wr_en  out  1  register-file write strobe, registered
- wr_addr  out  ADDR_W  registered write address
- wr_data  out  DATA_W  registered write data
- iss_valid  in  1  decode issues an instruction that will write iss_addr
- iss_addr  in  ADDR_W  destination of the issued instruction
- iss_ready  out  1  scoreboard can accept the issue
- rs1_en, rs2_en  in  1 each  source operand used
- rs1, rs2  in  ADDR_W each  source register addresses
- stall  out  1  a used source has an outstanding write
- busy  out  NREG  bit i = register i has an outstanding write
- err  out  1  sticky: a commit arrived with no outstanding write

## Operation
- Handshake: a transfer occurs when valid && ready in the same cycle. Requesters hold addr/data stable while valid && !ready.
- The output stage always accepts, so at most one grant is made per cycle. a_ready/b_ready are combinational from valid, rr and reset.
- Arbitration:
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester not recorded in rr.
  - rr records the last granted requester and updates on every grant.
  - A requester waits at most 1 cycle.
- Commit: on a grant, the winner's addr/data load into wr_addr/wr_data and wr_en=1 next cycle. With no grant, wr_en=0 and wr_addr/wr_data hold.
- Scoreboard: one 2-bit counter per register, cnt[i].
  - Issue (iss_valid && iss_ready) increments cnt[iss_addr].
  - Commit (wr_en==1) decrements cnt[wr_addr].
  - Same-cycle issue and commit to the same register: cnt unchanged.
  - iss_ready = !reset && cnt[iss_addr] != 3. Counters never wrap.
  - Commit with cnt[wr_addr]==0: counter stays 0 and err sets. err clears only on reset.
- busy[i] = cnt[i] != 0.
- stall = (rs1_en && busy[rs1]) || (rs2_en && busy[rs2]). Combinational from registered counts; there is no bypass of a same-cycle commit.
- All NREG registers, including register 0, are ordinary writable entries.

## Timing
- Grant in cycle N; wr_en/wr_addr/wr_data valid in cycle N+1. Latency from request to write strobe is 1 cycle.
- Commit in cycle N+1 decrements the counter at the end of N+1, so busy/stall clear from cycle N+2.
- Issue in cycle N makes busy visible from N+1.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, all cnt=0, busy=0, stall=0, err=0, rr=B (A wins first conflict).
- While reset is high: a_ready=b_ready=iss_ready=0 and no state advances except the reset load.
- Reset mid-operation:
  - An in-flight commit is dropped (wr_en=0 in the cycle after reset is sampled).
  - Outstanding counts are discarded.
  - Requesters must re-present after reset.

## Test plan
- Reset, then A writes reg4=0xEC -> cycle after grant: wr_en=1, wr_addr=4, wr_data=0xEC; a_ready was 1 in the request cycle.
- A and B both valid every cycle (A reg2=0x11, B reg3=0x22) -> grants alternate A,B,A,B starting with A; wr_en continuously 1; neither ready low for 2 consecutive cycles.
- Issue reg5 three times -> busy[5]=1 and iss_ready=0 for addr 5. A fourth issue is not accepted. Three commits to reg5 -> busy[5]=0 two cycles after the last grant.
- rs1=5, rs1_en=1 with busy[5]=1 -> stall=1. Same with rs1_en=0 -> stall=0. After the commit clears busy[5], stall=0 from grant+2.
- Same-cycle issue to reg3 and commit to reg3 at cnt=1 -> cnt stays 1, busy[3]=1. Commit to reg6 with cnt=0 -> err=1 and stays 1 until reset.
- Assert reset while wr_en=1 and cnt[2]=2 -> next cycle wr_en=0, busy=0, err=0. First post-reset conflict is granted to A.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: round-robin arbitration of two writeback
// requesters onto one registered write port, plus a per-register outstanding-write scoreboard.
module rf_wb_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  b_ready,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  iss_ready,
    input  logic                  rs1_en,
    input  logic [ADDR_W-1:0]     rs1,
    input  logic                  rs2_en,
    input  logic [ADDR_W-1:0]     rs2,
    output logic                  stall,
    output logic [2**ADDR_W-1:0]  busy,
    output logic                  err
);

    localparam int NREG = 2**ADDR_W;

    typedef enum logic {RR_A, RR_B} rr_t;

    rr_t        rr;
    logic [1:0] cnt [NREG];

    logic            a_grant;
    logic            b_grant;
    logic            iss_fire;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic            underflow;

    // On conflict the requester that did not win last time goes first.
    assign a_grant = !reset && a_valid && (!b_valid || rr == RR_B);
    assign b_grant = !reset && b_valid && (!a_valid || rr == RR_A);
    assign a_ready = a_grant;
    assign b_ready = b_grant;

    assign iss_ready = !reset && (cnt[iss_addr] != 2'd3);
    assign iss_fire  = iss_valid && iss_ready;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        busy    = '0;
        for (int i = 0; i < NREG; i++) begin
            inc_vec[i] = iss_fire && (iss_addr == ADDR_W'(i));
            dec_vec[i] = wr_en && (wr_addr == ADDR_W'(i));
            busy[i]    = (cnt[i] != 2'd0);
        end
    end

    // A commit matched by a same-cycle issue to the same register is not an underflow.
    assign underflow = wr_en && (cnt[wr_addr] == 2'd0)
                       && !(iss_fire && (iss_addr == wr_addr));

    // No bypass: a commit in flight still stalls readers this cycle.
    assign stall = (rs1_en && busy[rs1]) || (rs2_en && busy[rs2]);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            rr      <= RR_B;
            err     <= 1'b0;
            // NOTE: the counter array is small and its contents define busy/stall,
            // so it is reset explicitly rather than left as uninitialised memory.
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= 2'd0;
            end
        end else begin
            wr_en <= a_grant || b_grant;
            if (a_grant) begin
                wr_addr <= a_addr;
                wr_data <= a_data;
                rr      <= RR_A;
            end else if (b_grant) begin
                wr_addr <= b_addr;
                wr_data <= b_data;
                rr      <= RR_B;
            end

            for (int i = 0; i < NREG; i++) begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10: cnt[i] <= cnt[i] + 2'd1;
                    2'b01: if (cnt[i] != 2'd0) cnt[i] <= cnt[i] - 2'd1;
                    default: ;
                endcase
            end

            if (underflow) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter: arbitration, commit latency,
// scoreboard counting, stall, sticky error and mid-operation reset.
module tb_rf_wb_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid, b_valid;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       iss_valid;
    logic [2:0] iss_addr;
    logic       iss_ready;
    logic       rs1_en, rs2_en;
    logic [2:0] rs1, rs2;
    logic       stall;
    logic [7:0] busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .rs1_en(rs1_en), .rs1(rs1), .rs2_en(rs2_en), .rs2(rs2),
        .stall(stall), .busy(busy), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        iss_valid = 0; iss_addr = 0;
        rs1_en = 0; rs1 = 0; rs2_en = 0; rs2 = 0;

        // Readies held low while reset is high.
        tick();
        a_valid = 1; b_valid = 1; iss_valid = 1; iss_addr = 1;
        settle();
        check("rst_a_ready", 32'(a_ready), 0);
        check("rst_b_ready", 32'(b_ready), 0);
        check("rst_iss_ready", 32'(iss_ready), 0);
        tick();
        a_valid = 0; b_valid = 0; iss_valid = 0;
        reset = 0;
        rs1_en = 1; rs1 = 0;
        settle();
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_stall", 32'(stall), 0);
        rs1_en = 0;

        // A writes reg4=0xEC, with a matching issue in the same cycle.
        a_valid = 1; a_addr = 4; a_data = 8'hEC;
        iss_valid = 1; iss_addr = 4;
        settle();
        check("t1_a_ready", 32'(a_ready), 1);
        tick();
        a_valid = 0; iss_valid = 0;
        settle();
        check("t1_wr_en", 32'(wr_en), 1);
        check("t1_wr_addr", 32'(wr_addr), 4);
        check("t1_wr_data", 32'(wr_data), 32'hEC);
        check("t1_busy", 32'(busy), 32'h10);
        tick();
        check("t1_wr_en_off", 32'(wr_en), 0);
        check("t1_busy_clr", 32'(busy), 0);
        check("t1_err", 32'(err), 0);

        // Fresh reset so the first conflict goes to A.
        reset = 1;
        tick();
        reset = 0;
        iss_valid = 1;
        for (int k = 0; k < 4; k++) begin
            iss_addr = (k < 2) ? 3'd2 : 3'd3;
            tick();
        end
        iss_valid = 0;
        settle();
        check("t2_busy_pre", 32'(busy), 32'h0C);

        // Both valid every cycle: grants alternate A,B,A,B.
        a_valid = 1; a_addr = 2; a_data = 8'h11;
        b_valid = 1; b_addr = 3; b_data = 8'h22;
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("t2_a_ready_%0d", k), 32'(a_ready), (k % 2 == 0) ? 1 : 0);
            check($sformatf("t2_b_ready_%0d", k), 32'(b_ready), (k % 2 == 1) ? 1 : 0);
            tick();
            check($sformatf("t2_wr_en_%0d", k), 32'(wr_en), 1);
            check($sformatf("t2_wr_addr_%0d", k), 32'(wr_addr), (k % 2 == 0) ? 2 : 3);
            check($sformatf("t2_wr_data_%0d", k), 32'(wr_data), (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        a_valid = 0; b_valid = 0;
        tick();
        check("t2_wr_en_off", 32'(wr_en), 0);
        check("t2_busy_post", 32'(busy), 0);
        check("t2_err", 32'(err), 0);

        // Three issues to reg5 saturate its counter; a fourth is refused.
        iss_valid = 1; iss_addr = 5;
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("t3_iss_ready_%0d", k), 32'(iss_ready), 1);
            tick();
        end
        settle();
        check("t3_busy5", 32'(busy), 32'h20);
        check("t3_iss_ready_full", 32'(iss_ready), 0);
        tick();
        iss_valid = 0;
        rs1 = 5; rs1_en = 1;
        settle();
        check("t3_stall_rs1", 32'(stall), 1);
        rs1_en = 0;
        settle();
        check("t3_stall_rs1_off", 32'(stall), 0);
        rs2 = 5; rs2_en = 1;
        settle();
        check("t3_stall_rs2", 32'(stall), 1);
        rs2_en = 0; rs1_en = 1;

        // Three commits to reg5; busy/stall clear two cycles after the last grant.
        a_valid = 1; a_addr = 5;
        for (int k = 0; k < 3; k++) begin
            a_data = 8'(k + 1);
            tick();
        end
        a_valid = 0;
        settle();
        check("t3_last_wr_data", 32'(wr_data), 3);
        check("t3_busy_grant1", 32'(busy), 32'h20);
        check("t3_stall_grant1", 32'(stall), 1);
        tick();
        check("t3_busy_grant2", 32'(busy), 0);
        check("t3_stall_grant2", 32'(stall), 0);
        check("t3_err", 32'(err), 0);
        rs1_en = 0;

        // Same-cycle issue and commit to reg3 at cnt=1 leave the count at 1.
        iss_valid = 1; iss_addr = 3;
        tick();
        iss_valid = 0;
        a_valid = 1; a_addr = 3; a_data = 8'h33;
        tick();
        a_valid = 0;
        iss_valid = 1; iss_addr = 3;
        settle();
        check("t4_commit3", 32'(wr_en), 1);
        tick();
        iss_valid = 0;
        settle();
        check("t4_busy3", 32'(busy), 32'h08);
        check("t4_err0", 32'(err), 0);

        // Commit to reg6 with nothing outstanding sets the sticky error.
        a_valid = 1; a_addr = 6; a_data = 8'h66;
        tick();
        a_valid = 0;
        tick();
        check("t4_err_set", 32'(err), 1);
        check("t4_hold_wr_en", 32'(wr_en), 0);
        check("t4_hold_wr_addr", 32'(wr_addr), 6);
        check("t4_hold_wr_data", 32'(wr_data), 32'h66);
        check("t4_busy_after", 32'(busy), 32'h08);
        tick();
        tick();
        check("t4_err_sticky", 32'(err), 1);

        // Reset while a commit is in flight and cnt[2]=2.
        iss_valid = 1; iss_addr = 2;
        tick();
        tick();
        iss_valid = 0;
        a_valid = 1; a_addr = 2; a_data = 8'hA5;
        tick();
        a_valid = 0;
        settle();
        check("t5_inflight", 32'(wr_en), 1);
        check("t5_busy_pre", 32'(busy), 32'h0C);
        reset = 1;
        tick();
        check("t5_wr_en", 32'(wr_en), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_err", 32'(err), 0);
        reset = 0;
        a_valid = 1; a_addr = 1; a_data = 8'h5A;
        b_valid = 1; b_addr = 7; b_data = 8'h77;
        settle();
        check("t5_a_ready", 32'(a_ready), 1);
        check("t5_b_ready", 32'(b_ready), 0);
        tick();
        a_valid = 0; b_valid = 0;
        check("t5_wr_addr", 32'(wr_addr), 1);
        check("t5_wr_data", 32'(wr_data), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
